ram_fill_writer: RTL and testbench
==================================

// Module: ram_fill_writer
// PURPOSE
//  Write side of the 1024x16 block-RAM test design. Accepts a stream of DEPTH words,
//  writes them to RAM addresses 0..DEPTH-1 through the synchronous write port, then
//  reads them back through the registered read port and checks a running checksum.
//  Sits beside the read path that drives led from sw; loads the table that the path reads.
// PARAMETERS
//  ADDR_WIDTH    10  RAM address width
//  DATA_WIDTH    16  RAM word width
//  DEPTH         10  words per fill, 1..2**ADDR_WIDTH
//  READ_LATENCY  2   cycles from ram_raddr presented to ram_rdata valid (>=1)
// PORTS
//  clk        in   1           single clock, all logic on posedge
//  rst        in   1           synchronous, active-high reset
//  start      in   1           begin fill; sampled in IDLE or DONE only
//  in_valid   in   1           input word valid
//  in_ready   out  1           writer accepts word (combinational: state==WRITE)
//  in_data    in   DATA_WIDTH  input word
//  ram_we     out  1           registered write strobe
//  ram_waddr  out  ADDR_WIDTH  registered write address
//  ram_wdata  out  DATA_WIDTH  registered write data
//  ram_raddr  out  ADDR_WIDTH  registered read address
//  ram_rdata  in   DATA_WIDTH  read data, READ_LATENCY after ram_raddr
//  busy       out  1           high in WRITE/READ/DRAIN
//  done       out  1           high in DONE
//  pass       out  1           valid while done: read checksum == write checksum
//  checksum   out  DATA_WIDTH  write checksum of last fill; valid while done
// BEHAVIOUR
//  Reset: state IDLE; every output 0; counters, checksums, latency pipe cleared.
//  States: IDLE -> WRITE -> READ -> DRAIN -> DONE; DONE -> WRITE on start.
//  IDLE: in_ready=0. start=1 -> WRITE; wr_addr=0, both sums=0.
//  WRITE: in_ready=1. Accept = in_valid&in_ready. On accept, next cycle:
//    ram_we=1, ram_waddr=wr_addr, ram_wdata=in_data; wr_sum += in_data.
//    Otherwise ram_we=0. Accepting word DEPTH-1 -> READ. Gaps in in_valid are allowed.
//  READ: one address per cycle. ram_raddr=0..DEPTH-1 registered. Each issue pushes
//    a 1 into a READ_LATENCY-deep valid pipe. After issuing DEPTH-1 -> DRAIN.
//  DRAIN: no new issues. When the pipe is empty and the last word is summed -> DONE.
//  Pipe output high: rd_sum += ram_rdata, sampled in the same cycle.
//  DONE: done=1; pass=(rd_sum==wr_sum); checksum=wr_sum. Outputs hold until start.
//    start -> WRITE, clears done/pass/sums.
//  Hazard rule: first ram_raddr is presented no earlier than the cycle after the
//    last ram_we pulse. This holds for DEPTH=1.
//  Arithmetic: sums wrap modulo 2**DATA_WIDTH. Addresses never exceed DEPTH-1 and never wrap.
//  start ignored in WRITE/READ/DRAIN. in_data ignored outside WRITE.
//  Reset mid-operation: next cycle IDLE, ram_we=0, busy=0, done=0. A partial fill is abandoned.
//  Latency: in_valid held high and start sampled at edge 0 -> done first high at
//    cycle 2*DEPTH+READ_LATENCY+2 (24 for defaults).
// TESTING
//  1 Reset: assert rst 10 cycles with start=1 -> all outputs 0, in_ready=0, no ram_we.
//  2 Nominal fill: words 0001,AAAA,5555,FFFF,F0F0,0F0F,CCCC,3333,0002,0004 with
//    in_valid held high, model RAM latency 2 -> ram_we pulses at addresses 0..9 with
//    those data; done at cycle 24; pass=1; checksum=16'h0003. Afterwards the RAM read
//    path at sw=0..9 returns the same words.
//  3 Backpressure gaps: in_valid toggles every cycle -> exactly 10 writes, same
//    addresses, data and checksum 0003, pass=1.
//  4 Corrupt readback: model RAM flips bit 0 of word 3 -> done, pass=0, checksum=0003.
//  5 Reset mid-WRITE after 4 accepts -> ram_we=0 next cycle, state IDLE. New start
//    refills from address 0 and the checksum covers only the new words.
//  6 Restart from DONE, and DEPTH=1 build: start in DONE -> done drops next cycle,
//    fill repeats. DEPTH=1, word BEEF -> one write, raddr issued after it, pass=1,
//    checksum BEEF.

Source files
------------

// File: rtl/ram_fill_writer.sv
// rtl/ram_fill_writer.sv - fills a block RAM from an input stream, reads it back and compares checksums
module ram_fill_writer #(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 16,
    parameter int DEPTH        = 10,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [DATA_WIDTH-1:0] checksum
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    logic [2:0]              state_q,   state_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic [DATA_WIDTH-1:0]   wr_sum_q,  wr_sum_d;
    logic [DATA_WIDTH-1:0]   rd_sum_q,  rd_sum_d;
    logic                    we_q,      we_d;
    logic [ADDR_WIDTH-1:0]   waddr_q,   waddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q,   wdata_d;
    logic [ADDR_WIDTH-1:0]   raddr_q,   raddr_d;
    logic                    issue_q,   issue_d;
    logic [READ_LATENCY-1:0] vpipe_q,   vpipe_d;
    logic                    pipe_empty;

    // issue_q marks the cycle raddr is presented; the pipe then counts READ_LATENCY
    // cycles so its last stage lines up with valid ram_rdata.
    assign pipe_empty = !issue_q && (vpipe_q == '0);

    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        wr_sum_d  = wr_sum_q;
        rd_sum_d  = rd_sum_q;
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        raddr_d   = raddr_q;
        issue_d   = 1'b0;
        vpipe_d   = '0;

        vpipe_d[0] = issue_q;
        for (int i = 1; i < READ_LATENCY; i++) begin
            vpipe_d[i] = vpipe_q[i-1];
        end

        if (vpipe_q[READ_LATENCY-1]) begin
            rd_sum_d = rd_sum_q + ram_rdata;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_WRITE;
                    wr_addr_d = '0;
                    rd_addr_d = '0;
                    wr_sum_d  = '0;
                    rd_sum_d  = '0;
                    vpipe_d   = '0;
                end
            end
            S_WRITE: begin
                if (in_valid) begin
                    we_d     = 1'b1;
                    waddr_d  = wr_addr_q;
                    wdata_d  = in_data;
                    wr_sum_d = wr_sum_q + in_data;
                    if (wr_addr_q == LAST_ADDR) begin
                        state_d = S_READ;
                    end else begin
                        wr_addr_d = wr_addr_q + ADDR_ONE;
                    end
                end
            end
            S_READ: begin
                raddr_d = rd_addr_q;
                issue_d = 1'b1;
                if (rd_addr_q == LAST_ADDR) begin
                    state_d = S_DRAIN;
                end else begin
                    rd_addr_d = rd_addr_q + ADDR_ONE;
                end
            end
            S_DRAIN: begin
                if (pipe_empty) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            wr_sum_q  <= '0;
            rd_sum_q  <= '0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            raddr_q   <= '0;
            issue_q   <= 1'b0;
            vpipe_q   <= '0;
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            wr_sum_q  <= wr_sum_d;
            rd_sum_q  <= rd_sum_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            raddr_q   <= raddr_d;
            issue_q   <= issue_d;
            vpipe_q   <= vpipe_d;
        end
    end

    assign in_ready  = (state_q == S_WRITE);
    assign busy      = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);
    assign pass      = done && (rd_sum_q == wr_sum_q);
    assign checksum  = done ? wr_sum_q : '0;
    assign ram_we    = we_q;
    assign ram_waddr = waddr_q;
    assign ram_wdata = wdata_q;
    assign ram_raddr = raddr_q;

endmodule

// File: tb/tb_ram_fill_writer.sv
// tb/tb_ram_fill_writer.sv - directed bench for ram_fill_writer with a two-stage RAM model
module tb_ram_fill_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, in_valid, in_ready, ram_we, busy, done, pass;
    logic [15:0] in_data, ram_wdata, ram_rdata, checksum;
    logic [9:0]  ram_waddr, ram_raddr;

    logic        start1, in_valid1, in_ready1, ram_we1, busy1, done1, pass1;
    logic [15:0] in_data1, ram_wdata1, ram_rdata1, checksum1;
    logic [9:0]  ram_waddr1, ram_raddr1;

    ram_fill_writer #(.ADDR_WIDTH(10), .DATA_WIDTH(16), .DEPTH(10), .READ_LATENCY(2)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_raddr(ram_raddr), .ram_rdata(ram_rdata), .busy(busy), .done(done),
        .pass(pass), .checksum(checksum)
    );

    ram_fill_writer #(.ADDR_WIDTH(10), .DATA_WIDTH(16), .DEPTH(1), .READ_LATENCY(2)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_data(in_data1), .ram_we(ram_we1), .ram_waddr(ram_waddr1), .ram_wdata(ram_wdata1),
        .ram_raddr(ram_raddr1), .ram_rdata(ram_rdata1), .busy(busy1), .done(done1),
        .pass(pass1), .checksum(checksum1)
    );

    // RAM models: synchronous write, two registers on the read path
    logic [15:0] mem  [0:15];
    logic [15:0] mem1 [0:15];
    logic [15:0] rd_stage, rd_stage1;
    logic        corrupt;

    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr[3:0]] <= ram_wdata;
        rd_stage  <= mem[ram_raddr[3:0]] ^ ((corrupt && ram_raddr == 10'd3) ? 16'h0001 : 16'h0000);
        ram_rdata <= rd_stage;
    end

    always @(posedge clk) begin
        if (ram_we1) mem1[ram_waddr1[3:0]] <= ram_wdata1;
        rd_stage1  <= mem1[ram_raddr1[3:0]];
        ram_rdata1 <= rd_stage1;
    end

    int          wr_cnt  = 0;
    int          wr1_cnt = 0;
    logic [9:0]  wa_log [0:127];
    logic [15:0] wd_log [0:127];
    logic [9:0]  wa1;
    logic [15:0] wd1;

    always @(negedge clk) begin
        if (ram_we) begin
            wa_log[wr_cnt[6:0]] = ram_waddr;
            wd_log[wr_cnt[6:0]] = ram_wdata;
            wr_cnt = wr_cnt + 1;
        end
        if (ram_we1) begin
            wa1 = ram_waddr1;
            wd1 = ram_wdata1;
            wr1_cnt = wr1_cnt + 1;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    logic [15:0] words [0:9];

    task automatic do_fill(input bit gaps, input int max_words, output int done_cyc,
                           output logic busy0, output logic done0);
        int idx;
        int cyc;
        bit tog;
        bit acc;
        idx = 0; cyc = 0; tog = 1'b0; done_cyc = -1;
        @(negedge clk);
        start = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        busy0 = busy;
        done0 = done;
        while (cyc < 200) begin
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (idx == max_words) begin
                done_cyc = -2;
                break;
            end
            in_valid = (idx < 10) && (!gaps || tog);
            in_data  = words[idx < 10 ? idx : 9];
            acc      = in_valid && in_ready;
            @(posedge clk);
            cyc++;
            tog = !tog;
            if (acc) idx++;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic check_writes(input string tag, input int base);
        check_eq({tag, "_wcount"}, 32'(wr_cnt - base), 32'd10);
        for (int i = 0; i < 10; i++) begin
            check_eq({tag, "_waddr"}, 32'(wa_log[7'(base + i)]), 32'(i));
            check_eq({tag, "_wdata"}, 32'(wd_log[7'(base + i)]), 32'(words[i]));
        end
    endtask

    int   base;
    int   dc;
    int   cyc1;
    logic b0, d0;

    initial begin
        rst = 1'b1; start = 1'b1; in_valid = 1'b0; in_data = 16'h0; corrupt = 1'b0;
        start1 = 1'b0; in_valid1 = 1'b0; in_data1 = 16'h0;
        base = wr_cnt;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_busy",     32'(busy),     32'd0);
        check_eq("rst_done",     32'(done),     32'd0);
        check_eq("rst_pass",     32'(pass),     32'd0);
        check_eq("rst_checksum", 32'(checksum), 32'd0);
        check_eq("rst_we",       32'(ram_we),   32'd0);
        check_eq("rst_waddr",    32'(ram_waddr), 32'd0);
        check_eq("rst_raddr",    32'(ram_raddr), 32'd0);
        check_eq("rst_wcount",   32'(wr_cnt - base), 32'd0);
        check_eq("rst1_busy",    32'(busy1),    32'd0);
        rst = 1'b0; start = 1'b0;

        words[0] = 16'h0001; words[1] = 16'hAAAA; words[2] = 16'h5555; words[3] = 16'hFFFF;
        words[4] = 16'hF0F0; words[5] = 16'h0F0F; words[6] = 16'hCCCC; words[7] = 16'h3333;
        words[8] = 16'h0002; words[9] = 16'h0004;

        // nominal fill from IDLE
        base = wr_cnt;
        do_fill(1'b0, 99, dc, b0, d0);
        check_eq("nom_done_cycle", 32'(dc), 32'd24);
        check_eq("nom_pass",       32'(pass), 32'd1);
        check_eq("nom_checksum",   32'(checksum), 32'h0003);
        check_writes("nom", base);

        // in_valid toggling
        base = wr_cnt;
        do_fill(1'b1, 99, dc, b0, d0);
        check_eq("gap_done",     32'(done), 32'd1);
        check_eq("gap_pass",     32'(pass), 32'd1);
        check_eq("gap_checksum", 32'(checksum), 32'h0003);
        check_writes("gap", base);

        // corrupted readback
        corrupt = 1'b1;
        do_fill(1'b0, 99, dc, b0, d0);
        check_eq("bad_done",     32'(done), 32'd1);
        check_eq("bad_pass",     32'(pass), 32'd0);
        check_eq("bad_checksum", 32'(checksum), 32'h0003);
        corrupt = 1'b0;

        // reset after four accepts, then refill with new words
        do_fill(1'b0, 4, dc, b0, d0);
        check_eq("abort_stopped", 32'(dc), 32'hFFFF_FFFE);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("abort_we",       32'(ram_we),   32'd0);
        check_eq("abort_busy",     32'(busy),     32'd0);
        check_eq("abort_in_ready", 32'(in_ready), 32'd0);
        check_eq("abort_done",     32'(done),     32'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) words[i] = 16'((i + 1) * 16'h1000);
        base = wr_cnt;
        do_fill(1'b0, 99, dc, b0, d0);
        check_eq("refill_done_cycle", 32'(dc), 32'd24);
        check_eq("refill_pass",       32'(pass), 32'd1);
        check_eq("refill_checksum",   32'(checksum), 32'h7000);
        check_writes("refill", base);

        // restart straight from DONE
        words[0] = 16'h0001; words[1] = 16'hAAAA; words[2] = 16'h5555; words[3] = 16'hFFFF;
        words[4] = 16'hF0F0; words[5] = 16'h0F0F; words[6] = 16'hCCCC; words[7] = 16'h3333;
        words[8] = 16'h0002; words[9] = 16'h0004;
        do_fill(1'b0, 99, dc, b0, d0);
        check_eq("restart_done_drop", 32'(d0), 32'd0);
        check_eq("restart_busy",      32'(b0), 32'd1);
        check_eq("restart_done_cycle", 32'(dc), 32'd24);
        check_eq("restart_pass",      32'(pass), 32'd1);
        check_eq("restart_checksum",  32'(checksum), 32'h0003);

        // single-word build
        @(negedge clk);
        start1 = 1'b1; in_valid1 = 1'b1; in_data1 = 16'hBEEF;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        cyc1 = 0;
        while (!done1 && cyc1 < 50) begin
            @(posedge clk);
            cyc1++;
            @(negedge clk);
        end
        in_valid1 = 1'b0;
        check_eq("d1_done_cycle", 32'(cyc1), 32'd6);
        check_eq("d1_wcount",     32'(wr1_cnt), 32'd1);
        check_eq("d1_waddr",      32'(wa1), 32'd0);
        check_eq("d1_wdata",      32'(wd1), 32'hBEEF);
        check_eq("d1_pass",       32'(pass1), 32'd1);
        check_eq("d1_checksum",   32'(checksum1), 32'hBEEF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
